if_stage: RTL and testbench

- Instruction-fetch stage directly upstream of the decode stage.
- Owns the PC and a small fetch queue, and talks to instruction memory over a request/grant/response handshake.
- Drives the IF/ID pipeline register: PC and split instruction fields.
- Takes stall from the hazard unit and branch/jump redirects from decode.

---
 rtl/pipe_pkg.sv | 19 +
 rtl/if_fetch_buf.sv | 52 +++++
 rtl/if_stage.sv | 162 ++++++++++++++++
 tb/tb_if_stage.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline constants and the fetch-queue entry type used by the IF stage.
package pipe_pkg;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  localparam logic [6:0] OP_R      = 7'h33;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JAL    = 7'h6f;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_SYS    = 7'h73;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/if_fetch_buf.sv
// Two-entry synchronous FIFO of {pc, instr}; push while full is honoured only
// when a pop frees a slot in the same cycle.
module if_fetch_buf
  import pipe_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         clear,
  input  fetch_entry_t wdata,
  output fetch_entry_t rdata,
  output logic         full,
  output logic         empty,
  output logic [1:0]   count
);
  fetch_entry_t mem_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   count_q;
  logic         do_push;
  logic         do_pop;

  assign do_pop  = pop & (count_q != 2'd0);
  assign do_push = push & ((count_q != 2'd2) | do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (clear) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) wr_ptr_q <= ~wr_ptr_q;
      if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  // Storage needs no reset: entries are only read while count is non-zero.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = (count_q == 2'd2);
  assign empty = (count_q == 2'd0);
  assign count = count_q;
endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, credit-limited imem requests, in-order response
// queue with bypass, redirect/drop handling and the IF/ID pipeline register.
module if_stage
  import pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter int          FBUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        IF_flush,
  input  logic        jump,
  input  logic [31:0] EA,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IF_PC,
  output logic [6:0]  opcode_ID,
  output logic [4:0]  rd_ID,
  output logic [2:0]  funct3,
  output logic [4:0]  rs1_ID,
  output logic [4:0]  rs2_ID,
  output logic [6:0]  funct7,
  output logic        en,
  output logic        IF_flush_out,
  output logic        misalign_err
);
  logic [31:0] pc_q, pc_d;
  logic [3:0]  out_q, out_d;
  logic [3:0]  drop_q, drop_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ifpc_q, ifpc_d;
  logic        en_q, en_d;
  logic        fo_q, fo_d;
  logic        mis_q, mis_d;

  logic         redir, accept, rsp_drop, rsp_keep, bypass;
  logic [3:0]   inflight;
  logic [1:0]   q_count, t_count;
  logic         q_full, q_empty, t_full, t_empty;
  fetch_entry_t q_head, tag_rd;
  logic         bits_unused;

  assign redir    = (IF_flush | jump) & ~stall;
  assign inflight = out_q - drop_q;
  // Gating with rst_n keeps the request low while reset is asserted.
  assign imem_req = rst_n & ~stall & ~redir &
                    (({2'b00, q_count} + inflight) < 4'(FBUF_DEPTH));
  assign imem_addr = pc_q;
  assign accept    = imem_req & imem_gnt;
  assign rsp_drop  = (drop_q != 4'd0);
  assign rsp_keep  = imem_rvalid & ~rsp_drop & ~redir;
  assign bypass    = rsp_keep & ~stall & (q_count == 2'd0);

  // Tags exist only for non-dropped requests, so the tag FIFO is cleared on redirect.
  if_fetch_buf u_tags (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (accept),
    .pop   (rsp_keep),
    .clear (redir),
    .wdata ('{pc: pc_q, instr: 32'h0}),
    .rdata (tag_rd),
    .full  (t_full),
    .empty (t_empty),
    .count (t_count)
  );

  if_fetch_buf u_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rsp_keep & ~bypass),
    .pop   (~stall & ~redir & (q_count != 2'd0)),
    .clear (redir),
    .wdata ('{pc: tag_rd.pc, instr: imem_rdata}),
    .rdata (q_head),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  assign bits_unused = ^{q_full, q_empty, t_full, t_empty, t_count, tag_rd.instr};

  always_comb begin
    pc_d   = pc_q;
    mis_d  = mis_q;
    out_d  = out_q + {3'b000, accept} - {3'b000, imem_rvalid};
    drop_d = drop_q;
    if (redir) begin
      pc_d   = {EA[31:2], 2'b00};
      mis_d  = mis_q | (EA[1:0] != 2'b00);
      drop_d = out_d;
    end else begin
      if (accept) pc_d = pc_q + 32'd4;
      if (imem_rvalid && rsp_drop) drop_d = drop_q - 4'd1;
    end
  end

  always_comb begin
    instr_d = instr_q;
    ifpc_d  = ifpc_q;
    en_d    = en_q;
    fo_d    = fo_q;
    if (!stall) begin
      if (redir) begin
        instr_d = NOP_INSTR;
        en_d    = 1'b0;
        fo_d    = 1'b1;
      end else if (q_count != 2'd0) begin
        instr_d = q_head.instr;
        ifpc_d  = q_head.pc;
        en_d    = 1'b1;
        fo_d    = 1'b0;
      end else if (bypass) begin
        instr_d = imem_rdata;
        ifpc_d  = tag_rd.pc;
        en_d    = 1'b1;
        fo_d    = 1'b0;
      end else begin
        instr_d = NOP_INSTR;
        en_d    = 1'b0;
        fo_d    = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      out_q   <= 4'd0;
      drop_q  <= 4'd0;
      instr_q <= NOP_INSTR;
      ifpc_q  <= 32'h0;
      en_q    <= 1'b0;
      fo_q    <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      out_q   <= out_d;
      drop_q  <= drop_d;
      instr_q <= instr_d;
      ifpc_q  <= ifpc_d;
      en_q    <= en_d;
      fo_q    <= fo_d;
      mis_q   <= mis_d;
    end
  end

  assign IF_PC        = ifpc_q;
  assign opcode_ID    = instr_q[6:0];
  assign rd_ID        = instr_q[11:7];
  assign funct3       = instr_q[14:12];
  assign rs1_ID       = instr_q[19:15];
  assign rs2_ID       = instr_q[24:20];
  assign funct7       = instr_q[31:25];
  assign en           = en_q;
  assign IF_flush_out = fo_q;
  assign misalign_err = mis_q;
endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with an in-order, variable-latency imem model
// and a running expected-PC scoreboard for the IF/ID stream.
module tb_if_stage;
  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        IF_flush;
  logic        jump;
  logic [31:0] EA;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] IF_PC;
  logic [6:0]  opcode_ID;
  logic [4:0]  rd_ID;
  logic [2:0]  funct3;
  logic [4:0]  rs1_ID;
  logic [4:0]  rs2_ID;
  logic [6:0]  funct7;
  logic        en;
  logic        IF_flush_out;
  logic        misalign_err;

  int          total;
  int          bad;
  int          lat;
  int          cyc;
  logic [31:0] exp_pc;
  logic [31:0] snap;
  bit          seen;
  logic [31:0] pend_a[$];
  int          pend_t[$];

  if_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .IF_flush     (IF_flush),
    .jump         (jump),
    .EA           (EA),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_gnt     (imem_gnt),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .IF_PC        (IF_PC),
    .opcode_ID    (opcode_ID),
    .rd_ID        (rd_ID),
    .funct3       (funct3),
    .rs1_ID       (rs1_ID),
    .rs2_ID       (rs2_ID),
    .funct7       (funct7),
    .en           (en),
    .IF_flush_out (IF_flush_out),
    .misalign_err (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[26:2], 7'h33};
  endfunction

  function automatic logic [31:0] ifid_word();
    return {funct7, rs2_ID, rs1_ID, funct3, rd_ID, opcode_ID};
  endfunction

  // In-order memory: each accepted request answers 'lat' cycles later, one per cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_a.delete();
      pend_t.delete();
      cyc         <= 0;
      imem_rvalid <= 1'b0;
      imem_rdata  <= 32'h0;
    end else begin
      if (imem_req && imem_gnt) begin
        pend_a.push_back(imem_addr);
        pend_t.push_back(cyc + lat);
      end
      cyc <= cyc + 1;
      if (pend_a.size() > 0 && pend_t[0] <= cyc + 1) begin
        imem_rvalid <= 1'b1;
        imem_rdata  <= instr_of(pend_a[0]);
        void'(pend_a.pop_front());
        void'(pend_t.pop_front());
      end else begin
        imem_rvalid <= 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    logic st;
    st = stall;
    @(posedge clk);
    #1;
    chk("q_occ", 32'(dut.q_count <= 2'd2), 32'd1);
    if (!st && en) begin
      $display("fetch pc=%08h instr=%08h", IF_PC, ifid_word());
      chk("if_pc", IF_PC, exp_pc);
      chk("if_ins", ifid_word(), instr_of(exp_pc));
      exp_pc = exp_pc + 32'd4;
      seen = 1'b1;
    end
  endtask

  task automatic wait_fetch(input int budget, input string tag);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) tick();
    chk(tag, 32'(seen), 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"}, 32'(imem_req), 32'd0);
    chk({tag, "_en"}, 32'(en), 32'd0);
    chk({tag, "_fo"}, 32'(IF_flush_out), 32'd0);
    chk({tag, "_mis"}, 32'(misalign_err), 32'd0);
    chk({tag, "_pc"}, IF_PC, 32'h0);
    chk({tag, "_ins"}, ifid_word(), 32'h0000_0013);
    chk({tag, "_addr"}, imem_addr, 32'h0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    total = 0; bad = 0; lat = 1; exp_pc = 32'h0; seen = 1'b0;
    rst_n = 1'b0; stall = 1'b0; IF_flush = 1'b0; jump = 1'b0; EA = 32'h0;
    imem_gnt = 1'b1;

    // Reset state and first-fetch latency.
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("rst");
    rst_n = 1'b1;
    #1;
    chk("req_c1", 32'(imem_req), 32'd1);
    chk("addr_c1", imem_addr, 32'h0);
    tick();
    chk("en_c2", 32'(en), 32'd0);
    chk("addr_c2", imem_addr, 32'h4);
    tick();
    chk("en_c3", 32'(en), 32'd1);
    chk("addr_c3", imem_addr, 32'h8);
    repeat (5) tick();

    // Stall for three cycles.
    stall = 1'b1;
    #1;
    chk("req_stall", 32'(imem_req), 32'd0);
    snap = exp_pc - 32'd4;
    repeat (3) begin
      tick();
      chk("hold_pc", IF_PC, snap);
      chk("hold_req", 32'(imem_req), 32'd0);
    end
    stall = 1'b0;
    wait_fetch(4, "stall_resume");
    repeat (3) tick();

    // Taken branch with requests in flight.
    lat = 3;
    repeat (4) tick();
    IF_flush = 1'b1;
    EA = 32'h40;
    #1;
    chk("req_redir", 32'(imem_req), 32'd0);
    tick();
    IF_flush = 1'b0;
    chk("bub_en", 32'(en), 32'd0);
    chk("bub_fo", 32'(IF_flush_out), 32'd1);
    chk("bub_ins", ifid_word(), 32'h0000_0013);
    chk("addr_40", imem_addr, 32'h40);
    exp_pc = 32'h40;
    lat = 1;
    tick();
    chk("fo_1cyc", 32'(IF_flush_out), 32'd0);
    wait_fetch(10, "flush_resume");
    chk("mis_clean", 32'(misalign_err), 32'd0);
    repeat (3) tick();

    // Misaligned jump target.
    jump = 1'b1;
    EA = 32'h102;
    tick();
    jump = 1'b0;
    chk("mis_set", 32'(misalign_err), 32'd1);
    chk("addr_jmp", imem_addr, 32'h100);
    chk("jmp_fo", 32'(IF_flush_out), 32'd1);
    exp_pc = 32'h100;
    wait_fetch(10, "jump_resume");
    repeat (4) tick();
    chk("mis_sticky", 32'(misalign_err), 32'd1);

    // Grant withheld, then slow responses.
    imem_gnt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i >= 2) begin
        chk("gnt_req", 32'(imem_req), 32'd1);
        chk("gnt_addr", imem_addr, exp_pc);
      end
    end
    imem_gnt = 1'b1;
    lat = 3;
    wait_fetch(10, "gnt_resume");
    repeat (12) tick();
    lat = 1;
    repeat (3) tick();

    // Asynchronous reset with responses pending.
    lat = 3;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("arst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    lat = 1;
    exp_pc = 32'h0;
    wait_fetch(6, "rst_resume");
    repeat (4) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
